// File: rtl/disp_colr_adapt.sv
// disp_colr_adapt: two-stage colour-depth adapter (replicate, truncate or ordered dither) with matched coordinate/sync delay
module disp_colr_adapt #(
  parameter int BPC_IN  = 5,
  parameter int BPC_OUT = 8,
  parameter int CHANS   = 3,
  parameter int CORDW   = 16,
  parameter int DITHER  = 1
) (
  input  logic                     clk_pix,
  input  logic                     rst_pix_n,
  input  logic                     dither_en,
  input  logic [CORDW-1:0]         in_x,
  input  logic [CORDW-1:0]         in_y,
  input  logic                     in_de,
  input  logic                     in_frame,
  input  logic [CHANS*BPC_IN-1:0]  in_colr,
  output logic [CORDW-1:0]         out_x,
  output logic [CORDW-1:0]         out_y,
  output logic                     out_de,
  output logic                     out_frame,
  output logic [CHANS*BPC_OUT-1:0] out_colr
);
  if (BPC_IN < 1 || BPC_IN > 16 || BPC_OUT < 1 || BPC_OUT > 16 || CHANS < 1 || CHANS > 4 ||
      CORDW < 1 || DITHER < 0 || DITHER > 2) begin : g_bad_param
    $error("disp_colr_adapt: parameter out of range");
  end
  logic [CORDW-1:0]         x1, y1;
  logic                     de1, fr1;
  logic [CHANS*BPC_IN-1:0]  c1;
  logic [CHANS*BPC_OUT-1:0] adapt;
  always_ff @(posedge clk_pix or negedge rst_pix_n)
    if (!rst_pix_n) begin
      x1        <= '0;
      y1        <= '0;
      de1       <= 1'b0;
      fr1       <= 1'b0;
      c1        <= '0;
      out_x     <= '0;
      out_y     <= '0;
      out_de    <= 1'b0;
      out_frame <= 1'b0;
      out_colr  <= '0;
    end else begin
      x1        <= in_x;
      y1        <= in_y;
      de1       <= in_de;
      fr1       <= in_frame;
      c1        <= in_colr;
      out_x     <= x1;
      out_y     <= y1;
      out_de    <= de1;
      out_frame <= fr1;
      out_colr  <= de1 ? adapt : '0;
    end
  if (BPC_OUT < BPC_IN) begin : g_red
    localparam int D  = BPC_IN - BPC_OUT;
    localparam int SH = D >= 2 ? D - 2 : 0;
    logic [1:0]      phase, b;
    logic [BPC_IN:0] t, t1;
    always_comb begin
      b = {in_x[0] ^ in_y[0], in_y[0]} + (DITHER == 2 ? phase : 2'd0);
      t = (DITHER == 0 || !dither_en) ? '0 : D >= 2 ? (BPC_IN+1)'(b) << SH : (BPC_IN+1)'(b[1]);
    end
    always_ff @(posedge clk_pix or negedge rst_pix_n)
      if (!rst_pix_n) begin
        phase <= 2'd0;
        t1    <= '0;
      end else begin
        t1    <= t;
        phase <= in_frame ? phase + 2'd1 : phase;
      end
    for (genvar k = 0; k < CHANS; k++) begin : g_ch
      logic [BPC_IN:0] s;
      assign s = {1'b0, c1[k*BPC_IN +: BPC_IN]} + t1;
      assign adapt[k*BPC_OUT +: BPC_OUT] = s[BPC_IN] ? '1 : s[BPC_IN-1:D];
    end
  end else if (BPC_OUT == BPC_IN) begin : g_eq
    logic unused_dither;
    assign unused_dither = dither_en;
    assign adapt = c1;
  end else begin : g_exp
    logic unused_dither;
    assign unused_dither = dither_en;
    for (genvar k = 0; k < CHANS; k++) begin : g_ch
      for (genvar i = 0; i < BPC_OUT; i++) begin : g_bit
        assign adapt[k*BPC_OUT+i] = c1[k*BPC_IN + BPC_IN-1 - (BPC_OUT-1-i) % BPC_IN];
      end
    end
  end
endmodule

// File: tb/tb_disp_colr_adapt.sv
// tb_disp_colr_adapt: directed and random checks of expand, truncate and dither instances against an arithmetic model
module tb_disp_colr_adapt;
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic        de;
    logic        fr;
    logic [23:0] ce;
    logic [14:0] c0;
    logic [14:0] c1;
    logic [14:0] c2;
  } exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, den = 1'b0, de = 1'b0, fr = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic [14:0] c5 = '0;
  logic [23:0] c8 = '0;
  logic [15:0] e_x, e_y, r0_x, r0_y, r1_x, r1_y, r2_x, r2_y;
  logic        e_de, e_fr, r0_de, r0_fr, r1_de, r1_fr, r2_de, r2_fr;
  logic [23:0] e_c;
  logic [14:0] r0_c, r1_c, r2_c;
  int          checks = 0, errors = 0, ph = 0;
  exp_t        q[$];
  always #5 clk = ~clk;
  disp_colr_adapt u_exp (.clk_pix(clk), .rst_pix_n(rst_n), .dither_en(den), .in_x(x), .in_y(y), .in_de(de),
    .in_frame(fr), .in_colr(c5), .out_x(e_x), .out_y(e_y), .out_de(e_de), .out_frame(e_fr), .out_colr(e_c));
  disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .DITHER(0)) u_r0 (.clk_pix(clk), .rst_pix_n(rst_n), .dither_en(den),
    .in_x(x), .in_y(y), .in_de(de), .in_frame(fr), .in_colr(c8), .out_x(r0_x), .out_y(r0_y), .out_de(r0_de),
    .out_frame(r0_fr), .out_colr(r0_c));
  disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .DITHER(1)) u_r1 (.clk_pix(clk), .rst_pix_n(rst_n), .dither_en(den),
    .in_x(x), .in_y(y), .in_de(de), .in_frame(fr), .in_colr(c8), .out_x(r1_x), .out_y(r1_y), .out_de(r1_de),
    .out_frame(r1_fr), .out_colr(r1_c));
  disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .DITHER(2)) u_r2 (.clk_pix(clk), .rst_pix_n(rst_n), .dither_en(den),
    .in_x(x), .in_y(y), .in_de(de), .in_frame(fr), .in_colr(c8), .out_x(r2_x), .out_y(r2_y), .out_de(r2_de),
    .out_frame(r2_fr), .out_colr(r2_c));
  function automatic logic [4:0] red(int c, int x0, int y0, int mode, int p, bit en);
    int bay[4] = '{0, 2, 3, 1};
    int b, s;
    if (!en || mode == 0) return 5'(c / 8);
    b = bay[2*y0 + x0];
    if (mode == 2) b = (b + p) % 4;
    s = (c + 2*b) / 8;
    return s > 31 ? 5'd31 : 5'(s);
  endfunction
  task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic apply(int nx, int ny, bit nde, bit nfr, bit nden, logic [14:0] n5, logic [23:0] n8);
    exp_t h, e;
    int cc, x0, y0;
    @(negedge clk);
    h = q.pop_front();
    chk("exp_x", e_x, h.x);
    chk("exp_y", e_y, h.y);
    chk("exp_de", e_de, h.de);
    chk("exp_frame", e_fr, h.fr);
    chk("exp_colr", e_c, h.ce);
    chk("trunc_colr", r0_c, h.c0);
    chk("d1_colr", r1_c, h.c1);
    chk("d1_y", r1_y, h.y);
    chk("d2_colr", r2_c, h.c2);
    chk("d2_x", r2_x, h.x);
    chk("d2_de", r2_de, h.de);
    chk("d2_frame", r2_fr, h.fr);
    chk("d0_frame", r0_fr, h.fr);
    x = 16'(nx); y = 16'(ny); de = nde; fr = nfr; den = nden; c5 = n5; c8 = n8;
    x0 = nx & 1; y0 = ny & 1;
    e = '0;
    e.x = x; e.y = y; e.de = nde; e.fr = nfr;
    if (nde)
      for (int ch = 0; ch < 3; ch++) begin
        cc = int'(n5[5*ch +: 5]);
        e.ce[8*ch +: 8] = 8'(cc * 8 + cc / 4);
        cc = int'(n8[8*ch +: 8]);
        e.c0[5*ch +: 5] = red(cc, x0, y0, 0, ph, nden);
        e.c1[5*ch +: 5] = red(cc, x0, y0, 1, ph, nden);
        e.c2[5*ch +: 5] = red(cc, x0, y0, 2, ph, nden);
      end
    if (nfr) ph = (ph + 1) % 4;
    q.push_back(e);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_exp_colr", e_c, 0);
    chk("rst_d1_colr", r1_c, 0);
    chk("rst_d2_colr", r2_c, 0);
    chk("rst_exp_x", e_x, 0);
    chk("rst_d2_y", r2_y, 0);
    chk("rst_exp_de", e_de, 0);
    chk("rst_d2_frame", r2_fr, 0);
    @(negedge clk);
    x = '0; y = '0; de = 1'b0; fr = 1'b0; c5 = '0; c8 = '0;
    rst_n = 1'b1;
    q.delete();
    q.push_back('0);
    q.push_back('0);
    ph = 0;
  endtask
  initial begin
    do_reset();
    apply(3, 4, 1, 0, 0, {5'h01, 5'h10, 5'h1F}, {8'hFF, 8'h87, 8'h07});
    apply(5, 6, 1, 0, 0, {5'h1F, 5'h00, 5'h0A}, {8'h07, 8'hFF, 8'h87});
    apply(0, 0, 1, 0, 1, 15'h1234, {3{8'h84}});
    apply(1, 0, 1, 0, 1, 15'h4321, {3{8'h84}});
    apply(0, 1, 1, 0, 1, 15'h7FFF, {3{8'h84}});
    apply(1, 1, 1, 0, 1, 15'h0001, {3{8'h84}});
    apply(0, 1, 1, 0, 1, 15'h0421, {8'hFF, 8'h84, 8'hFF});
    apply(9, 9, 0, 1, 1, 15'h0, 24'h0);
    apply(0, 0, 1, 0, 1, 15'h0, {3{8'h84}});
    apply(1, 1, 1, 0, 1, 15'h0, {3{8'h84}});
    apply(2, 2, 1, 1, 1, 15'h0, {3{8'h84}});
    apply(3, 3, 1, 1, 1, 15'h0, {3{8'h84}});
    apply(0, 0, 1, 0, 1, 15'h0, {3{8'h84}});
    apply(1, 0, 1, 0, 1, 15'h0, {3{8'h84}});
    apply(0, 1, 1, 0, 0, 15'h0, {3{8'h84}});
    apply(-1, -1, 1, 0, 1, 15'h0, {3{8'h84}});
    apply(-3, 7, 0, 0, 1, 15'h7FFF, 24'hFFFFFF);
    apply(-2, -5, 1, 1, 1, 15'h5555, 24'hA5C3F0);
    do_reset();
    apply(4, 2, 1, 0, 1, 15'h7FFF, {8'hFF, 8'h84, 8'h87});
    apply(0, 0, 0, 0, 1, 15'h0, 24'h0);
    apply(0, 0, 0, 0, 1, 15'h0, 24'h0);
    for (int n = 0; n < 300; n++) begin
      if (n == 150) do_reset();
      apply(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0,
            15'($urandom), 24'($urandom));
    end
    apply(0, 0, 0, 0, 0, 15'h0, 24'h0);
    apply(0, 0, 0, 0, 0, 15'h0, 24'h0);
    apply(0, 0, 0, 0, 0, 15'h0, 24'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
